// File: rtl/iac_rot.sv
// iac_rot: group-1 operate back end of the PDP-8 datapath.
//
// Takes the AC value and link that come out of the clear/OR/invert stage. It then
// applies IAC, followed by RAL/RAR/RTL/RTR/BSW in group-1 order, one micro-step
// per clock. The final AC and LINK go back to write-back through a start/done
// handshake.
//
// Ports:
//   CLK    - system clock, rising edge
//   RESET_ - asynchronous active-low reset; aborts any operation in flight
//   IN     - AC value from the clear/OR/invert stage
//   LIN    - link value after CLL/CML
//   IAC    - increment {LINK,AC}
//   RAL    - rotate left
//   RAR    - rotate right
//   TWICE  - with RAL/RAR: rotate twice; alone: byte swap (BSW)
//   START  - one-cycle request, sampled only while idle
//   BUSY   - operation in progress
//   DONE   - one-cycle completion strobe
//   AC     - result accumulator
//   LINK   - result link
module iac_rot #(
   parameter int unsigned WIDTH = 12
) (
   input  logic             CLK,
   input  logic             RESET_,
   input  logic [WIDTH-1:0] IN,
   input  logic             LIN,
   input  logic             IAC,
   input  logic             RAL,
   input  logic             RAR,
   input  logic             TWICE,
   input  logic             START,
   output logic             BUSY,
   output logic             DONE,
   output logic [WIDTH-1:0] AC,
   output logic             LINK
);

   localparam int unsigned Half = WIDTH / 2;

   typedef enum logic [2:0] {
      StIdle,
      StInc,
      StRot1,
      StRot2,
      StBsw,
      StFin
   } state_e;

   state_e           state_q;
   logic [WIDTH-1:0] ac_q;
   logic             link_q;
   logic             busy_q;
   logic             done_q;
   logic             iac_q;
   logic             ral_q;
   logic             rar_q;
   logic             twice_q;

   // Step that follows the (optional) increment. A rotation needs exactly one
   // direction: RAL and RAR together cancel the rotate, and TWICE then does not
   // turn into BSW.
   function automatic state_e after_inc(input logic ral, input logic rar, input logic twice);
      if (ral ^ rar) begin
         return StRot1;
      end else if (twice && !ral && !rar) begin
         return StBsw;
      end else begin
         return StFin;
      end
   endfunction

   function automatic state_e first_step(input logic iac, input logic ral, input logic rar,
                                         input logic twice);
      if (iac) begin
         return StInc;
      end else begin
         return after_inc(ral, rar, twice);
      end
   endfunction

   state_e           first_st;
   state_e           post_inc_st;
   logic [WIDTH:0]   inc_val;
   logic [WIDTH:0]   rot_val;
   logic [WIDTH-1:0] bsw_val;

   always_comb begin
      first_st    = first_step(IAC, RAL, RAR, TWICE);
      post_inc_st = after_inc(ral_q, rar_q, twice_q);
      // A carry out of AC flips LINK. 1_7777 wraps to 0_0000.
      inc_val     = {link_q, ac_q} + {{WIDTH{1'b0}}, 1'b1};
      // Rotation on the WIDTH+1 bit ring {LINK,AC}. The rot states are entered only
      // when exactly one direction is latched.
      rot_val     = ral_q ? {ac_q, link_q} : {ac_q[0], link_q, ac_q[WIDTH-1:1]};
      bsw_val     = {ac_q[Half-1:0], ac_q[WIDTH-1:Half]};
   end

   always_ff @(posedge CLK or negedge RESET_) begin
      if (!RESET_) begin
         state_q <= StIdle;
         ac_q    <= '0;
         link_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         iac_q   <= 1'b0;
         ral_q   <= 1'b0;
         rar_q   <= 1'b0;
         twice_q <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (START) begin
                  ac_q    <= IN;
                  link_q  <= LIN;
                  iac_q   <= IAC;
                  ral_q   <= RAL;
                  rar_q   <= RAR;
                  twice_q <= TWICE;
                  busy_q  <= 1'b1;
                  state_q <= first_st;
                  done_q  <= (first_st == StFin);
               end
            end
            StInc: begin
               {link_q, ac_q} <= inc_val;
               state_q        <= post_inc_st;
               done_q         <= (post_inc_st == StFin);
            end
            StRot1: begin
               {link_q, ac_q} <= rot_val;
               if (twice_q) begin
                  state_q <= StRot2;
               end else begin
                  state_q <= StFin;
                  done_q  <= 1'b1;
               end
            end
            StRot2: begin
               {link_q, ac_q} <= rot_val;
               state_q        <= StFin;
               done_q         <= 1'b1;
            end
            StBsw: begin
               ac_q    <= bsw_val;
               state_q <= StFin;
               done_q  <= 1'b1;
            end
            StFin: begin
               // START seen here is dropped; a new request must arrive while idle.
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign BUSY = busy_q;
   assign DONE = done_q;
   assign AC   = ac_q;
   assign LINK = link_q;

endmodule

// File: tb/tb_iac_rot.sv
// tb_iac_rot: directed self-checking bench for iac_rot.
// Each observation is {BUSY,DONE,LINK,AC}. Values are sampled 1 time unit after
// the rising edge.
module tb_iac_rot;

   logic        CLK;
   logic        RESET_;
   logic [11:0] IN;
   logic        LIN;
   logic        IAC;
   logic        RAL;
   logic        RAR;
   logic        TWICE;
   logic        START;
   logic        BUSY;
   logic        DONE;
   logic [11:0] AC;
   logic        LINK;

   int n_chk;
   int n_pass;

   iac_rot #(.WIDTH(12)) dut (
      .CLK   (CLK),
      .RESET_(RESET_),
      .IN    (IN),
      .LIN   (LIN),
      .IAC   (IAC),
      .RAL   (RAL),
      .RAR   (RAR),
      .TWICE (TWICE),
      .START (START),
      .BUSY  (BUSY),
      .DONE  (DONE),
      .AC    (AC),
      .LINK  (LINK)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Present a request, clock edge E0, then drop START and scramble controls.
   task automatic start_op(input logic [11:0] in_v, input logic lin_v, input logic iac_v,
                           input logic ral_v, input logic rar_v, input logic twice_v);
      IN = in_v; LIN = lin_v; IAC = iac_v; RAL = ral_v; RAR = rar_v; TWICE = twice_v;
      START = 1'b1;
      tick();
      START = 1'b0;
      IN = 12'o0000; LIN = ~lin_v; IAC = 1'b0; RAL = 1'b0; RAR = 1'b0; TWICE = 1'b0;
   endtask

   task automatic test_reset();
      logic [14:0] exp;
      exp = {1'b0, 1'b0, 1'b0, 12'o0000};
      n_chk++;
      if ({BUSY, DONE, LINK, AC} !== exp)
         $display("FAIL reset_state: got %b want %b", {BUSY, DONE, LINK, AC}, exp);
      else n_pass++;
   endtask

   task automatic test_iac();
      logic [14:0] exp;
      start_op(12'o7777, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      exp = {1'b1, 1'b0, 1'b0, 12'o7777};
      n_chk++;
      if ({BUSY, DONE, LINK, AC} !== exp)
         $display("FAIL iac_e0: got %b want %b", {BUSY, DONE, LINK, AC}, exp);
      else n_pass++;
      tick();
      exp = {1'b1, 1'b1, 1'b1, 12'o0000};
      n_chk++;
      if ({BUSY, DONE, LINK, AC} !== exp)
         $display("FAIL iac_e1: got %b want %b", {BUSY, DONE, LINK, AC}, exp);
      else n_pass++;
      tick();
      exp = {1'b0, 1'b0, 1'b1, 12'o0000};
      n_chk++;
      if ({BUSY, DONE, LINK, AC} !== exp)
         $display("FAIL iac_idle: got %b want %b", {BUSY, DONE, LINK, AC}, exp);
      else n_pass++;
      tick();
      n_chk++;
      if ({BUSY, DONE, LINK, AC} !== exp)
         $display("FAIL iac_hold: got %b want %b", {BUSY, DONE, LINK, AC}, exp);
      else n_pass++;
   endtask

   task automatic test_ral();
      logic [14:0] exp;
      start_op(12'o4000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      exp = {1'b1, 1'b1, 1'b1, 12'o0000};
      n_chk++;
      if ({BUSY, DONE, LINK, AC} !== exp)
         $display("FAIL ral_e1: got %b want %b", {BUSY, DONE, LINK, AC}, exp);
      else n_pass++;
      tick();
      exp = {1'b0, 1'b0, 1'b1, 12'o0000};
      n_chk++;
      if ({BUSY, DONE, LINK, AC} !== exp)
         $display("FAIL ral_idle: got %b want %b", {BUSY, DONE, LINK, AC}, exp);
      else n_pass++;
   endtask

   task automatic test_rtr();
      logic [14:0] exp;
      start_op(12'o0001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      tick();
      exp = {1'b1, 1'b0, 1'b1, 12'o4000};
      n_chk++;
      if ({BUSY, DONE, LINK, AC} !== exp)
         $display("FAIL rtr_e1: got %b want %b", {BUSY, DONE, LINK, AC}, exp);
      else n_pass++;
      tick();
      exp = {1'b1, 1'b1, 1'b0, 12'o6000};
      n_chk++;
      if ({BUSY, DONE, LINK, AC} !== exp)
         $display("FAIL rtr_e2: got %b want %b", {BUSY, DONE, LINK, AC}, exp);
      else n_pass++;
      tick();
      exp = {1'b0, 1'b0, 1'b0, 12'o6000};
      n_chk++;
      if ({BUSY, DONE, LINK, AC} !== exp)
         $display("FAIL rtr_idle: got %b want %b", {BUSY, DONE, LINK, AC}, exp);
      else n_pass++;
   endtask

   task automatic test_iac_ral();
      logic [14:0] exp;
      start_op(12'o3777, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
      exp = {1'b1, 1'b0, 1'b0, 12'o4000};
      n_chk++;
      if ({BUSY, DONE, LINK, AC} !== exp)
         $display("FAIL iac_ral_e1: got %b want %b", {BUSY, DONE, LINK, AC}, exp);
      else n_pass++;
      tick();
      exp = {1'b1, 1'b1, 1'b1, 12'o0000};
      n_chk++;
      if ({BUSY, DONE, LINK, AC} !== exp)
         $display("FAIL iac_ral_e2: got %b want %b", {BUSY, DONE, LINK, AC}, exp);
      else n_pass++;
      tick();
   endtask

   task automatic test_no_rot();
      logic [14:0] exp;
      // RAL+RAR cancel the rotate but IAC still applies.
      start_op(12'o0010, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
      tick();
      exp = {1'b1, 1'b1, 1'b0, 12'o0011};
      n_chk++;
      if ({BUSY, DONE, LINK, AC} !== exp)
         $display("FAIL norot_iac: got %b want %b", {BUSY, DONE, LINK, AC}, exp);
      else n_pass++;
      tick();
   endtask

   task automatic test_back_to_back();
      logic [14:0] exp;
      start_op(12'o1234, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      exp = {1'b1, 1'b1, 1'b1, 12'o3412};
      n_chk++;
      if ({BUSY, DONE, LINK, AC} !== exp)
         $display("FAIL bsw_e1: got %b want %b", {BUSY, DONE, LINK, AC}, exp);
      else n_pass++;
      // START offered during FIN must be dropped.
      IN = 12'o7777; LIN = 1'b0; IAC = 1'b1; START = 1'b1;
      tick();
      START = 1'b0; IAC = 1'b0;
      exp = {1'b0, 1'b0, 1'b1, 12'o3412};
      n_chk++;
      if ({BUSY, DONE, LINK, AC} !== exp)
         $display("FAIL fin_start_ignored: got %b want %b", {BUSY, DONE, LINK, AC}, exp);
      else n_pass++;
      start_op(12'o5555, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
      exp = {1'b1, 1'b1, 1'b1, 12'o5555};
      n_chk++;
      if ({BUSY, DONE, LINK, AC} !== exp)
         $display("FAIL zero_step_e0: got %b want %b", {BUSY, DONE, LINK, AC}, exp);
      else n_pass++;
      tick();
      exp = {1'b0, 1'b0, 1'b1, 12'o5555};
      n_chk++;
      if ({BUSY, DONE, LINK, AC} !== exp)
         $display("FAIL zero_step_idle: got %b want %b", {BUSY, DONE, LINK, AC}, exp);
      else n_pass++;
   endtask

   task automatic test_start_busy();
      logic [14:0] exp;
      start_op(12'o0001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      IN = 12'o7777; LIN = 1'b0; IAC = 1'b1; RAL = 1'b1; START = 1'b1;
      tick();
      START = 1'b0;
      exp = {1'b1, 1'b0, 1'b1, 12'o4000};
      n_chk++;
      if ({BUSY, DONE, LINK, AC} !== exp)
         $display("FAIL busy_start_e1: got %b want %b", {BUSY, DONE, LINK, AC}, exp);
      else n_pass++;
      tick();
      exp = {1'b1, 1'b1, 1'b0, 12'o6000};
      n_chk++;
      if ({BUSY, DONE, LINK, AC} !== exp)
         $display("FAIL busy_start_e2: got %b want %b", {BUSY, DONE, LINK, AC}, exp);
      else n_pass++;
      tick();
      tick();
      exp = {1'b0, 1'b0, 1'b0, 12'o6000};
      n_chk++;
      if ({BUSY, DONE, LINK, AC} !== exp)
         $display("FAIL busy_start_idle: got %b want %b", {BUSY, DONE, LINK, AC}, exp);
      else n_pass++;
      IAC = 1'b0; RAL = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [14:0] exp;
      start_op(12'o0001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
      RESET_ = 1'b0;
      #1;
      exp = {1'b0, 1'b0, 1'b0, 12'o0000};
      n_chk++;
      if ({BUSY, DONE, LINK, AC} !== exp)
         $display("FAIL reset_abort: got %b want %b", {BUSY, DONE, LINK, AC}, exp);
      else n_pass++;
      tick();
      tick();
      n_chk++;
      if ({BUSY, DONE, LINK, AC} !== exp)
         $display("FAIL reset_no_done: got %b want %b", {BUSY, DONE, LINK, AC}, exp);
      else n_pass++;
      RESET_ = 1'b1;
      tick();
      start_op(12'o0001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      exp = {1'b1, 1'b0, 1'b0, 12'o0001};
      n_chk++;
      if ({BUSY, DONE, LINK, AC} !== exp)
         $display("FAIL post_reset_e0: got %b want %b", {BUSY, DONE, LINK, AC}, exp);
      else n_pass++;
      tick();
      exp = {1'b1, 1'b1, 1'b0, 12'o0002};
      n_chk++;
      if ({BUSY, DONE, LINK, AC} !== exp)
         $display("FAIL post_reset_e1: got %b want %b", {BUSY, DONE, LINK, AC}, exp);
      else n_pass++;
      tick();
      exp = {1'b0, 1'b0, 1'b0, 12'o0002};
      n_chk++;
      if ({BUSY, DONE, LINK, AC} !== exp)
         $display("FAIL post_reset_idle: got %b want %b", {BUSY, DONE, LINK, AC}, exp);
      else n_pass++;
   endtask

   initial begin
      n_chk = 0;
      n_pass = 0;
      RESET_ = 1'b0;
      IN = 12'o0000; LIN = 1'b0; IAC = 1'b0; RAL = 1'b0; RAR = 1'b0; TWICE = 1'b0;
      START = 1'b0;
      tick();
      tick();
      test_reset();
      RESET_ = 1'b1;
      tick();
      test_iac();
      test_ral();
      test_rtr();
      test_iac_ral();
      test_no_rot();
      test_back_to_back();
      test_start_busy();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
